// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch (master) and the prefetch queue (slave).
// Carries flush, both valid/ready channels and the occupancy count.
interface fetch_queue_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [CNT_W-1:0]  count;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch and IF/ID, flushed on branch redirect.
// Optional zero-latency empty-queue bypass when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  fetch_queue_if.slave   bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = DATA_W + ADDR_W;

  logic [ENT_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [ENT_W-1:0] r_head;

  logic             w_push;
  logic             w_pop;
  logic             w_byp_take;
  logic [PTR_W-1:0] w_wr_nxt;
  logic [PTR_W-1:0] w_rd_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ENT_W-1:0] w_head_nxt;
  logic [ENT_W-1:0] w_in_ent;
  logic [ENT_W-1:0] w_out_ent;

  assign w_in_ent = {bus.in_pc, bus.in_instr};

`ifdef FETCH_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass   = (r_count == '0) & bus.in_valid & ~bus.flush;
  // An entry handed straight to decode never touches the storage.
  assign w_byp_take = w_bypass & bus.out_ready;
  assign w_out_ent  = r_out_valid ? r_head : (w_bypass ? w_in_ent : '0);
  assign bus.out_valid = r_out_valid | w_bypass;
`else
  assign w_byp_take = 1'b0;
  assign w_out_ent  = r_head;
  assign bus.out_valid = r_out_valid;
`endif

  assign w_push = bus.in_valid & r_in_ready & ~bus.flush & ~w_byp_take;
  assign w_pop  = r_out_valid & bus.out_ready & ~bus.flush;

  assign bus.in_ready  = r_in_ready;
  assign bus.count     = r_count;
  assign bus.out_instr = w_out_ent[DATA_W-1:0];
  assign bus.out_pc    = w_out_ent[ENT_W-1:DATA_W];

  // Next pointer and occupancy values; flush overrides push and pop.
  always_comb begin
    w_wr_nxt  = r_wr_ptr;
    w_rd_nxt  = r_rd_ptr;
    w_cnt_nxt = r_count;
    if (bus.flush) begin
      w_wr_nxt  = '0;
      w_rd_nxt  = '0;
      w_cnt_nxt = '0;
    end else begin
      if (w_push) begin
        w_wr_nxt = r_wr_ptr + PTR_W'(1);
      end else begin
        w_wr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_nxt = r_rd_ptr + PTR_W'(1);
      end else begin
        w_rd_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
        2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
        default: w_cnt_nxt = r_count;
      endcase
    end
  end

  // Next head entry; the incoming write lands on the head slot when the queue drains to it.
  always_comb begin
    w_head_nxt = '0;
    if (w_cnt_nxt == '0) begin
      w_head_nxt = '0;
    end else if (w_push && (r_wr_ptr == w_rd_nxt)) begin
      w_head_nxt = w_in_ent;
    end else begin
      w_head_nxt = r_mem[w_rd_nxt];
    end
  end

  // Control state and registered output flags/head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_head      <= '0;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_count     <= w_cnt_nxt;
      r_in_ready  <= (w_cnt_nxt != CNT_W'(DEPTH));
      r_out_valid <= (w_cnt_nxt != '0);
      r_head      <= w_head_nxt;
    end
  end

  // Entry storage, intentionally left unreset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_ent;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed scenarios followed by random traffic.
module tb_fetch_queue;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 4;
  localparam int ENT_W  = DATA_W + ADDR_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  fetch_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [ENT_W-1:0] exp_q [$];
  int pre_size = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Producer side: check occupancy/in_ready and record accepted entries.
  always @(negedge clk) begin
    if (rst_n) begin
      pre_size = exp_q.size();
      check("count", 32'(bus.count), 32'(pre_size));
      check("in_ready", 32'(bus.in_ready), 32'(pre_size != DEPTH));
      if (bus.in_valid && (pre_size != DEPTH) && !bus.flush)
        exp_q.push_back({bus.in_pc, bus.in_instr});
    end
  end

  // Monitor: compare the head against the model and retire consumed entries.
  always @(negedge clk) begin
    logic exp_v;
    logic [ENT_W-1:0] head;
    #1;
    if (rst_n) begin
`ifdef FETCH_QUEUE_BYPASS_EN
      exp_v = (exp_q.size() != 0);
`else
      exp_v = (pre_size != 0);
`endif
      check("out_valid", 32'(bus.out_valid), 32'(exp_v));
      if (exp_v) begin
        head = exp_q[0];
        check("out_instr", 32'(bus.out_instr), 32'(head[DATA_W-1:0]));
        check("out_pc", 32'(bus.out_pc), 32'(head[ENT_W-1:DATA_W]));
        if (bus.out_ready && !bus.flush) void'(exp_q.pop_front());
      end else begin
        check("out_instr_zero", 32'(bus.out_instr), 32'd0);
        check("out_pc_zero", 32'(bus.out_pc), 32'd0);
      end
      if (bus.flush) exp_q.delete();
    end
  end

  task automatic cyc(input logic v, input logic [15:0] ins, input logic rdy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = ins;
    bus.in_pc     = ins ^ 16'h5A5A;
    bus.out_ready = rdy;
    bus.flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_instr", 32'(bus.out_instr), 32'd0);
    check("rst_out_pc", 32'(bus.out_pc), 32'd0);
  endtask

  initial begin
    int pv;
    int pr;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.in_pc     = 16'h0000;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_state();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Fill to full, then a refused fifth push held stable.
    cyc(1'b1, 16'h1111, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 1'b0, 1'b0);
    cyc(1'b1, 16'h4444, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 1'b0, 1'b0);
    // Drain in order.
    for (int i = 0; i < 5; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Sustained push&pop at count 2 across the pointer wrap.
    cyc(1'b1, 16'h0101, 1'b0, 1'b0);
    cyc(1'b1, 16'h0202, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Flush at count 3 with push and pop requested.
    cyc(1'b1, 16'h0A01, 1'b0, 1'b0);
    cyc(1'b1, 16'h0A02, 1'b0, 1'b0);
    cyc(1'b1, 16'h0A03, 1'b0, 1'b0);
    cyc(1'b1, 16'hAAAA, 1'b1, 1'b1);
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Empty queue, push with decode ready (bypass or one-cycle latency).
    cyc(1'b1, 16'hABCD, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Reset mid-stream at count 3.
    cyc(1'b1, 16'h0C01, 1'b0, 1'b0);
    cyc(1'b1, 16'h0C02, 1'b0, 1'b0);
    cyc(1'b1, 16'h0C03, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_state();
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // Random traffic with shifting push/pop bias.
    for (int i = 0; i < 3000; i++) begin
      if ((i % 500) == 0) begin
        pv = $urandom_range(20, 90);
        pr = $urandom_range(20, 90);
      end
      cyc(($urandom_range(0, 99) < pv) ? 1'b1 : 1'b0,
          16'($urandom),
          ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
          ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
